// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
// Parity framing is selected at build time with TDM_DEMUX_PARITY_EN.
package tdm_pkg;

    localparam int unsigned NchDefault = 4;
    localparam int unsigned WDefault   = 8;

    typedef enum logic {
        StHunt,
        StRun
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_sipo.sv
// W-bit serial-in parallel-out shift register, MSB arrives first.
module tdm_slot_sipo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            // Cast drops the oldest bit; also valid for W = 1
            q <= W'({q, din});
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: hunts for fsync, then splits each frame into NCH W-bit slots.
// Define TDM_DEMUX_PARITY_EN to add a trailing even-parity bit per frame.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NchDefault,
    parameter int unsigned W   = WDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             sdi_en,
    input  logic             fsync,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_strobe,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             par_err
);

    localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SW = $clog2(NCH + 1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    tdm_state_e       state_q;
    logic [BW-1:0]    bit_q, cur_bit;
    logic [SW-1:0]    slot_q, cur_slot;
    logic [NCH*W-1:0] ch_data_q;
    logic [NCH-1:0]   ch_strobe_q;
    logic             frame_valid_q, sync_err_q;
    logic [W-1:0]     sipo_q, word;
    logic             take, restart, err, go_hunt, par_phase, last_bit, shift_en;
`ifdef TDM_DEMUX_PARITY_EN
    logic             par_acc_q, par_err_q;
`endif

    tdm_slot_sipo #(
        .W (W)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .din      (sdi),
        .q        (sipo_q)
    );

    always_comb begin
        take    = 1'b0;
        restart = 1'b0;
        err     = 1'b0;
        go_hunt = 1'b0;
        if (sdi_en) begin
            if (state_q == StHunt) begin
                take    = fsync;
                restart = fsync;
            end else if (bit_q == '0 && slot_q == '0) begin
                // Frame boundary: only an fsync-marked bit may continue
                if (fsync) begin
                    take    = 1'b1;
                    restart = 1'b1;
                end else begin
                    err     = 1'b1;
                    go_hunt = 1'b1;
                end
            end else begin
                take    = 1'b1;
                err     = fsync;
                restart = fsync;
            end
        end
        cur_bit   = restart ? '0 : bit_q;
        cur_slot  = restart ? '0 : slot_q;
        par_phase = ParityEn && (cur_slot == SW'(NCH));
        last_bit  = (cur_bit == BW'(W - 1));
        shift_en  = take && !par_phase;
        // Completed slot word includes the bit arriving this cycle
        word      = W'({sipo_q, sdi});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            bit_q         <= '0;
            slot_q        <= '0;
            ch_data_q     <= '0;
            ch_strobe_q   <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_acc_q     <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            ch_strobe_q   <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= err;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q     <= 1'b0;
`endif
            if (go_hunt) begin
                state_q <= StHunt;
            end
            if (take) begin
                state_q <= StRun;
                if (par_phase) begin
                    frame_valid_q <= 1'b1;
                    bit_q         <= '0;
                    slot_q        <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                    par_err_q     <= sdi ^ par_acc_q;
`endif
                end else begin
`ifdef TDM_DEMUX_PARITY_EN
                    par_acc_q <= (restart ? 1'b0 : par_acc_q) ^ sdi;
`endif
                    if (last_bit) begin
                        bit_q <= '0;
                        for (int k = 0; k < NCH; k++) begin
                            if (cur_slot == SW'(k)) begin
                                ch_data_q[k*W +: W] <= word;
                                ch_strobe_q[k]      <= 1'b1;
                            end
                        end
                        if (!ParityEn && cur_slot == SW'(NCH - 1)) begin
                            frame_valid_q <= 1'b1;
                            slot_q        <= '0;
                        end else begin
                            slot_q <= cur_slot + SW'(1);
                        end
                    end else begin
                        bit_q  <= cur_bit + BW'(1);
                        slot_q <= cur_slot;
                    end
                end
            end
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_strobe   = ch_strobe_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err     = par_err_q;
`else
    assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, W=8) with a per-cycle expected-output scoreboard.
// Build with TDM_DEMUX_PARITY_EN to exercise the parity bit.
module tb_tdm_demux;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned FB  = NCH * W;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n, sdi, sdi_en, fsync;
    logic [FB-1:0]  ch_data;
    logic [NCH-1:0] ch_strobe;
    logic           frame_valid, sync_err, par_err;

    typedef struct packed {
        logic [NCH-1:0] stb;
        logic           fv;
        logic           se;
        logic           pe;
        logic [FB-1:0]  data;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [FB-1:0] exp_data;

    always #5 clk = ~clk;

    tdm_demux #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdi         (sdi),
        .sdi_en      (sdi_en),
        .fsync       (fsync),
        .ch_data     (ch_data),
        .ch_strobe   (ch_strobe),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .par_err     (par_err)
    );

    // Each driven cycle queues the outputs expected just after the next clock edge
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert ({ch_strobe, frame_valid, sync_err, par_err, ch_data} === e) else begin
                errors++;
                $error("FAIL cycle_out obs stb=%b fv=%b se=%b pe=%b data=%h exp stb=%b fv=%b se=%b pe=%b data=%h",
                       ch_strobe, frame_valid, sync_err, par_err, ch_data,
                       e.stb, e.fv, e.se, e.pe, e.data);
            end
        end
    end

    task automatic cyc(input logic en, input logic b, input logic fs, input logic [NCH-1:0] stb,
                       input logic fv, input logic se, input logic pe);
        exp_t e;
        sdi_en = en;
        sdi    = b;
        fsync  = fs;
        e.stb  = stb;
        e.fv   = fv;
        e.se   = se;
        e.pe   = pe;
        e.data = exp_data;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Unqualified cycle with fsync high and random data: must be ignored
    task automatic idle_bit();
        cyc(1'b0, 1'($urandom), 1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends the first nbits of frame fr (slot k = fr[k*W +: W], MSB first), fsync on bit 0
    task automatic send_frame(input logic [FB-1:0] fr, input bit toggle, input bit se_first,
                              input logic pbit, input int nbits);
        int n = 0;
        for (int s = 0; s < NCH; s++) begin
            for (int i = W - 1; i >= 0; i--) begin
                logic           first;
                logic [NCH-1:0] stb;
                if (n < nbits) begin
                    first = (s == 0 && i == W - 1);
                    stb   = '0;
                    if (i == 0) begin
                        exp_data[s*W +: W] = fr[s*W +: W];
                        stb[s]             = 1'b1;
                    end
                    cyc(1'b1, fr[s*W+i], first, stb, (i == 0 && s == NCH - 1 && !PAR),
                        first && se_first, 1'b0);
                    if (toggle) idle_bit();
                end
                n++;
            end
        end
        if (PAR && nbits >= int'(FB)) begin
            cyc(1'b1, pbit, 1'b0, '0, 1'b1, 1'b0, pbit != ^fr);
            if (toggle) idle_bit();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        sdi      = 1'b0;
        sdi_en   = 1'b0;
        fsync    = 1'b0;
        exp_data = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        assert ({ch_strobe, frame_valid, sync_err, par_err, ch_data} === '0) else begin
            errors++;
            $error("FAIL reset_state obs %b exp 0", {ch_strobe, frame_valid, sync_err, par_err, ch_data});
        end
        rst_n = 1'b1;

        // Hunting: qualified bits without fsync and unqualified fsync are discarded
        repeat (3) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_bit();

        send_frame(32'h00FF3CA5, 1'b0, 1'b0, ^32'h00FF3CA5, FB);
        // Back-to-back frame with sdi_en toggling
        send_frame(32'h00FF3CA5, 1'b1, 1'b0, ^32'h00FF3CA5, FB);

        // fsync reasserted at bit 3 of slot 2 restarts the frame on that bit
        send_frame(32'h11223344, 1'b0, 1'b0, 1'b0, 2 * W + 3);
        send_frame(32'h5A6B7C8D, 1'b0, 1'b1, ^32'h5A6B7C8D, FB);

        // Frame boundary without fsync: error, then hunt ignores bits
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        send_frame(32'hDEADBEEF, 1'b0, 1'b0, ^32'hDEADBEEF, FB);

        // Asynchronous reset during slot 1
        send_frame(32'hCAFE1234, 1'b0, 1'b0, 1'b0, W + 3);
        rst_n = 1'b0;
        #1;
        checks++;
        assert ({ch_strobe, frame_valid, sync_err, par_err, ch_data} === '0) else begin
            errors++;
            $error("FAIL async_reset obs %b exp 0", {ch_strobe, frame_valid, sync_err, par_err, ch_data});
        end
        exp_data = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h87654321, 1'b0, 1'b0, ^32'h87654321, FB);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(32'h00000001, 1'b0, 1'b0, 1'b0, FB);
        send_frame(32'h00000001, 1'b0, 1'b0, 1'b1, FB);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain obs %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of TDM channels (slots) per frame, range 2..16.
REQ-002 SHALL have parameter W, default 8, meaning bits per slot, range 1..16.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sdi  input  1  serial data bit, MSB of each slot first.
REQ-006 SHALL have port sdi_en  input  1  sdi valid this cycle; cycles with sdi_en=0 are ignored.
REQ-007 SHALL have port fsync  input  1  frame start marker, qualified by sdi_en, coincident with bit 0 of slot 0.
REQ-008 SHALL have port ch_data  output  NCH*W  registered channel words, slot k at bits [k*W +: W].
REQ-009 SHALL have port ch_strobe  output  NCH  one-cycle pulse per slot when that slot's word updates.
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse when a complete frame has been received.
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 SHALL have port par_err  output  1  one-cycle parity mismatch pulse, coincident with frame_valid.

Function
REQ-013 SHALL implement states HUNT and RUN; it leaves reset in HUNT.
REQ-014 In HUNT, SHALL discard every qualified bit without fsync; a qualified bit with fsync=1 SHALL be taken as bit 0 of slot 0, with transition to RUN.
REQ-015 In RUN, SHALL shift each qualified bit into the current slot shift register, MSB first, and advance bit/slot counters; counters SHALL hold when sdi_en=0.
REQ-016 On the last bit of slot k, SHALL load ch_data slot k and pulse ch_strobe[k] in the following cycle (latency 1 clk); other slots SHALL hold their value.
REQ-017 SHALL pulse frame_valid in the cycle after the last bit of the frame (slot NCH-1, or the parity bit when enabled).
REQ-018 After a complete frame, SHALL stay in RUN; if the next qualified bit has fsync=1, a new frame SHALL start with no gap.
REQ-019 If the next qualified bit after a complete frame has fsync=0, SHALL pulse sync_err, discard the bit, and go to HUNT.
REQ-020 If fsync=1 arrives mid-frame in RUN, SHALL pulse sync_err, drop the partial slot without updating ch_data, and restart at bit 0 of slot 0 using that bit.
REQ-021 sync_err SHALL be registered (1-clk latency after the offending bit); simultaneous frame completion and error SHALL NOT occur, since fsync mid-frame pre-empts completion.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear ch_data, ch_strobe, frame_valid, sync_err, par_err, the counters and shift registers, and force HUNT.
REQ-023 Reset mid-frame SHALL discard the partial frame; no strobe SHALL fire after release until a new fsync-qualified frame completes.

Configuration
REQ-024 With TDM_DEMUX_PARITY_EN defined, each frame SHALL carry one extra bit after slot NCH-1: even parity over all NCH*W data bits.
REQ-025 With the macro defined, par_err SHALL pulse with frame_valid when parity mismatches; ch_data SHALL still update.
REQ-026 Without the macro, the frame length SHALL be NCH*W bits and par_err SHALL be tied to 0.

Structure
REQ-027 Package tdm_pkg SHALL hold the state enum (HUNT, RUN) and the default NCH/W constants.
REQ-028 The W-bit serial-in parallel-out register SHALL be sub-module tdm_slot_sipo (ports clk, rst_n, shift_en, din, q), instantiated once and reused across slots.

Verification (NCH=4, W=8)
REQ-029 Frame 0xA5,0x3C,0xFF,0x00 with fsync on the first bit -> ch_strobe[0..3] pulse in order, ch_data=0x00FF3CA5, frame_valid=1 for 1 clk, sync_err=0.
REQ-030 Same frame with sdi_en toggling 1/0 every cycle -> identical ch_data and strobes; each strobe falls 1 clk after that slot's last qualified bit.
REQ-031 fsync reasserted at bit 3 of slot 2 -> sync_err pulse, slot 2 unchanged, following full frame decoded correctly.
REQ-032 Complete frame followed by a qualified bit with fsync=0 -> sync_err, HUNT, bits ignored until next fsync.
REQ-033 rst_n low during slot 1 -> all outputs 0 immediately, no strobe after release until a new complete frame.
REQ-034 With TDM_DEMUX_PARITY_EN, frame 0x01,0,0,0 with parity bit 0 -> par_err=1 with frame_valid; parity bit 1 -> par_err=0.
